// File: rtl/laplacian_stream.sv
// Streaming 3x3 Laplacian with centre-pixel alignment for the sharpening adder.
// Define LAPLACIAN_DIAG_EN for the 8-neighbour kernel; otherwise the 4-neighbour kernel is built.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FILL   | priming line buffers with the first IMG_WIDTH+1 pixels
// S_RUN    | one output per accepted pixel, centre lags input by IMG_WIDTH+1
// S_FLUSH  | input closed, emitting the last IMG_WIDTH+1 outputs
module laplacian_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 9,
    parameter int OUT_W      = 21
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PIX_W-1:0]        img,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    stall,
    output logic signed [OUT_W-1:0] sharpened_image,
    output logic [PIX_W-1:0]        img_out,
    output logic                    out_valid,
    output logic                    frame_end
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
`ifdef LAPLACIAN_DIAG_EN
    localparam int DEPTH = 2*IMG_WIDTH + 2;
`else
    localparam int DEPTH = 2*IMG_WIDTH + 1;
`endif
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    in_col, c_col;
    logic [RW-1:0]    in_row, c_row;
    logic [PIX_W-1:0] sr [DEPTH];
    logic [PIX_W-1:0] newest;
    logic             accept, advance, emit, border;
    logic signed [OUT_W-1:0] lap;

    function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{(OUT_W-PIX_W){1'b0}}, p});
    endfunction

    always_comb begin
        in_ready = reset & ~stall & (state != S_FLUSH);
        accept   = in_valid & in_ready;
        advance  = accept | (~stall & (state == S_FLUSH));
        emit     = ((state == S_RUN) & accept) | ((state == S_FLUSH) & ~stall);
        newest   = (state == S_FLUSH) ? '0 : img;
        border   = (c_row == '0) | (c_row == ROW_LAST) | (c_col == '0) | (c_col == COL_LAST);
    end

    // sr[j] holds the pixel accepted j+1 advances ago; the centre sits at sr[IMG_WIDTH]
    always_comb begin
`ifdef LAPLACIAN_DIAG_EN
        lap = (ext(sr[IMG_WIDTH]) <<< 3)
            - ext(sr[2*IMG_WIDTH]) - ext(sr[0])
            - ext(sr[IMG_WIDTH-1]) - ext(sr[IMG_WIDTH+1])
            - ext(sr[2*IMG_WIDTH+1]) - ext(sr[2*IMG_WIDTH-1])
            - ext(sr[1]) - ext(newest);
`else
        lap = (ext(sr[IMG_WIDTH]) <<< 2)
            - ext(sr[2*IMG_WIDTH]) - ext(sr[0])
            - ext(sr[IMG_WIDTH-1]) - ext(sr[IMG_WIDTH+1]);
`endif
    end

    // Line-buffer contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int i = DEPTH-1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= newest;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_FILL;
            in_col          <= '0;
            in_row          <= '0;
            c_col           <= '0;
            c_row           <= '0;
            sharpened_image <= '0;
            img_out         <= '0;
            out_valid       <= 1'b0;
            frame_end       <= 1'b0;
        end else if (!stall) begin
            out_valid <= emit;
            frame_end <= emit & (c_row == ROW_LAST) & (c_col == COL_LAST);
            if (emit) begin
                sharpened_image <= border ? '0 : lap;
                img_out         <= sr[IMG_WIDTH];
                if (c_col == COL_LAST) begin
                    c_col <= '0;
                    c_row <= (c_row == ROW_LAST) ? '0 : c_row + 1'b1;
                end else begin
                    c_col <= c_col + 1'b1;
                end
            end
            if (accept) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            case (state)
                S_FILL:  if (accept && in_row == RW'(1) && in_col == '0) state <= S_RUN;
                S_RUN:   if (accept && in_row == ROW_LAST && in_col == COL_LAST) state <= S_FLUSH;
                S_FLUSH: begin
                    if (c_row == ROW_LAST && c_col == COL_LAST) begin
                        state  <= S_FILL;
                        in_col <= '0;
                        in_row <= '0;
                        c_col  <= '0;
                        c_row  <= '0;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule
